// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS types, ALU control codes and multiply/divide decodes
package mips_pkg;

  // Operation selector for the multiply/divide unit: bit 1 = divide, bit 0 = unsigned
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } muldiv_state_t;

  // Main decoder -> ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU decoder -> ALU
  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;

  // R-type funct codes handled by the multiply/divide unit and HI/LO moves
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  function automatic logic md_is_signed(input muldiv_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input muldiv_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mips_muldiv_cond_neg.sv
// rtl/mips_muldiv_cond_neg.sv - conditional two's-complement negate
module cond_neg #(
  parameter int WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/mips_muldiv.sv
// rtl/mips_muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module mips_muldiv
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  muldiv_state_t    r_state, w_next;
  muldiv_op_t       r_op;
  logic             r_sign_a, r_sign_b, r_bzero;
  logic [WIDTH:0]   r_b;        // multiplicand or divisor magnitude
  logic [2*WIDTH:0] r_acc;      // {upper WIDTH+1, lower WIDTH}
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_done;

  muldiv_op_t       w_op;
  logic             w_signed, w_neg_a, w_neg_b, w_accept;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic [WIDTH:0]   w_sum, w_shift, w_rem_next;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quo, w_rem;

  assign w_op     = muldiv_op_t'(op);
  assign w_signed = md_is_signed(w_op);
  assign w_neg_a  = w_signed & srca[WIDTH-1];
  assign w_neg_b  = w_signed & srcb[WIDTH-1];
  assign w_accept = (r_state == MD_IDLE) && start;

  // Operand magnitudes on entry
  cond_neg #(.WIDTH(WIDTH)) u_mag_a (.i_neg(w_neg_a), .i_val(srca), .o_val(w_mag_a));
  cond_neg #(.WIDTH(WIDTH)) u_mag_b (.i_neg(w_neg_b), .i_val(srcb), .o_val(w_mag_b));

  // Multiply step: add multiplicand when the low multiplier bit is set, then shift right
  assign w_sum = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? r_b : '0);

  // Divide step: shift in next dividend bit and trial-subtract the divisor
  assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = {1'b0, w_shift} - {1'b0, r_b};
  assign w_ge       = ~w_diff[WIDTH+1];
  assign w_rem_next = w_ge ? w_diff[WIDTH:0] : w_shift;

  // Sign correction; quotient of a zero divisor stays all ones regardless of sign
  cond_neg #(.WIDTH(2*WIDTH)) u_prod (
    .i_neg(r_sign_a ^ r_sign_b), .i_val(r_acc[2*WIDTH-1:0]), .o_val(w_prod));
  cond_neg #(.WIDTH(WIDTH)) u_quo (
    .i_neg((r_sign_a ^ r_sign_b) & ~r_bzero), .i_val(r_acc[WIDTH-1:0]), .o_val(w_quo));
  cond_neg #(.WIDTH(WIDTH)) u_rem (
    .i_neg(r_sign_a), .i_val(r_acc[2*WIDTH-1:WIDTH]), .o_val(w_rem));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= MD_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and busy decode
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    case (r_state)
      MD_IDLE: if (start) w_next = MD_RUN;
      MD_RUN: begin
        busy = 1'b1;
        if (r_count == CW'(1)) w_next = MD_FIX;
      end
      MD_FIX: begin
        busy   = 1'b1;
        w_next = MD_IDLE;
      end
      default: w_next = MD_IDLE;
    endcase
  end

  // Operand latch, iteration datapath and counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op     <= MD_MULT;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_bzero  <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (w_accept) begin
      r_op     <= w_op;
      r_sign_a <= w_neg_a;
      r_sign_b <= w_neg_b;
      r_bzero  <= (srcb == '0);
      r_b      <= {1'b0, w_mag_b};
      r_acc    <= {{(WIDTH+1){1'b0}}, w_mag_a};
      r_count  <= CW'(WIDTH);
    end else if (r_state == MD_RUN) begin
      r_count <= r_count - CW'(1);
      if (md_is_div(r_op)) r_acc <= {w_rem_next, r_acc[WIDTH-2:0], w_ge};
      else                 r_acc <= {1'b0, w_sum, r_acc[WIDTH-1:1]};
    end
  end

  // HI/LO: results at FIX, MTHI/MTLO only while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == MD_FIX) begin
      if (md_is_div(r_op)) begin
        r_hi <= w_rem;
        r_lo <= w_quo;
      end else begin
        r_hi <= w_prod[2*WIDTH-1:WIDTH];
        r_lo <= w_prod[WIDTH-1:0];
      end
    end else if (r_state == MD_IDLE) begin
      if (hi_we) r_hi <= wd;
      if (lo_we) r_lo <= wd;
    end
  end

  // Completion pulse, one cycle after FIX
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_done <= 1'b0;
    else        r_done <= (r_state == MD_FIX);
  end

  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mips_muldiv.sv
// tb/tb_mips_muldiv.sv - directed self-checking bench for mips_muldiv
module tb_mips_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srca = '0, srcb = '0, wd = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        start8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [7:0]  a8 = '0, b8 = '0, wd8 = '0;
  logic        hi_we8 = 1'b0, lo_we8 = 1'b0;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int n_checks = 0;
  int n_errors = 0;

  mips_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd), .busy(busy), .done(done), .hi(hi), .lo(lo));

  mips_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .srca(a8), .srcb(b8),
    .hi_we(hi_we8), .lo_we(lo_we8), .wd(wd8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an operation with start for one edge; returns at cycle 1
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; srca = a; srcb = b; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Wait for done from cycle cyc0, checking busy during the run and latency
  task automatic wait_done(input string tag, input int cyc0);
    int cyc = cyc0;
    int busy_bad = 0;
    while (!done && cyc < 100) begin
      if (!busy) busy_bad++;
      step();
      cyc++;
    end
    check({tag, " latency"}, cyc, 34);
    check({tag, " busy_run"}, busy_bad, 0);
    check({tag, " busy_at_done"}, busy, 0);
  endtask

  initial begin
    int done_seen;
    int cyc;

    #12;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst hi", hi, 0);
    check("rst lo", lo, 0);
    check("rst8 hilo", {hi8, lo8}, 0);
    step();
    reset = 1'b1;
    step();

    issue(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult", 1);
    check("mult hi", hi, 32'hFFFF_FFFF);
    check("mult lo", lo, 32'hFFFF_FFEB);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu", 1);
    check("multu hi", hi, 32'hFFFF_FFFE);
    check("multu lo", lo, 32'h0000_0001);
    issue(2'b11, 32'd100, 32'd7);
    wait_done("divu b2b", 1);
    check("divu hi", hi, 32'd2);
    check("divu lo", lo, 32'd14);

    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done("div neg", 1);
    check("div neg hi", hi, 32'hFFFF_FFFF);
    check("div neg lo", lo, 32'hFFFF_FFFD);

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div ovf", 1);
    check("div ovf hi", hi, 32'h0);
    check("div ovf lo", lo, 32'h8000_0000);

    issue(2'b10, 32'hFFFF_FFF8, 32'h0);
    wait_done("div by0", 1);
    check("div by0 hi", hi, 32'hFFFF_FFF8);
    check("div by0 lo", lo, 32'hFFFF_FFFF);

    issue(2'b11, 32'h1234_5678, 32'h0);
    repeat (4) step();
    op = 2'b00; srca = 32'd3; srcb = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    wait_done("divu by0", 6);
    check("divu by0 hi", hi, 32'h1234_5678);
    check("divu by0 lo", lo, 32'hFFFF_FFFF);
    step();
    check("single done", done, 0);
    check("no queued op", busy, 0);

    hi_we = 1'b1; wd = 32'hA5A5_A5A5;
    step();
    hi_we = 1'b0;
    check("mthi", hi, 32'hA5A5_A5A5);
    lo_we = 1'b1; wd = 32'h5A5A_5A5A;
    step();
    lo_we = 1'b0;
    check("mtlo", lo, 32'h5A5A_5A5A);
    check("mtlo keeps hi", hi, 32'hA5A5_A5A5);

    issue(2'b01, 32'd3, 32'd5);
    repeat (3) step();
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'h1111_1111;
    step();
    hi_we = 1'b0; lo_we = 1'b0;
    check("busy mthi ignored", hi, 32'hA5A5_A5A5);
    check("busy mtlo ignored", lo, 32'h5A5A_5A5A);
    wait_done("multu small", 5);
    check("multu small hi", hi, 32'd0);
    check("multu small lo", lo, 32'd15);

    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    repeat (9) step();
    reset = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort hi", hi, 0);
    check("abort lo", lo, 0);
    done_seen = 0;
    repeat (2) begin
      step();
      if (done) done_seen++;
    end
    reset = 1'b1;
    repeat (40) begin
      step();
      if (done) done_seen++;
    end
    check("abort no done", done_seen, 0);
    check("abort idle", busy, 0);

    op8 = 2'b00; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    step();
    start8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 50) begin
      step();
      cyc++;
    end
    check("w8 latency", cyc, 10);
    check("w8 hi", hi8, 8'h40);
    check("w8 lo", lo8, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
Iterative multiply/divide unit with HI/LO registers for the MIPS core. It adds MULT, MULTU, DIV, DIVU, MTHI and MTLO to the existing single-cycle ALU set. It is parametrised in WIDTH and sits beside the alu in the datapath. The controller stalls PC and register writeback while busy=1.

Parameters:
WIDTH, 32, operand and HI/LO width; legal range is 4 to 64.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset; 0 clears all state immediately
start  in  1  request an operation; sampled only in IDLE
op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
srca  in  WIDTH  multiplicand or dividend (rs)
srcb  in  WIDTH  multiplier or divisor (rt)
hi_we  in  1  MTHI write enable
lo_we  in  1  MTLO write enable
wd  in  WIDTH  MTHI/MTLO write data
busy  out  1  operation in flight
done  out  1  one-cycle pulse; hi and lo are valid in this cycle
hi  out  WIDTH  HI register (product upper half, or remainder)
lo  out  WIDTH  LO register (product lower half, or quotient)

Behaviour:
- Reset: while reset=0, state=IDLE and busy, done, hi, lo and all internal registers are 0. Deassertion is synchronous to clk through the flop's async-clear release.
- States: IDLE, RUN, FIX.
  - IDLE -> RUN on start=1. In the same edge: latch op, latch the sign flags, latch magnitudes |srca| and |srcb| for signed ops (raw values for unsigned), set count=WIDTH.
  - RUN: one iteration per cycle, count decrements. RUN -> FIX when count reaches 1 (exactly WIDTH RUN cycles).
  - FIX: apply sign correction, write hi/lo, assert done. FIX -> IDLE unconditionally.
- Multiply: radix-2 shift-add on a 2*WIDTH accumulator. Signed product = negate(2*WIDTH magnitude product) when sign(srca) xor sign(srcb). hi = upper WIDTH bits, lo = lower WIDTH bits.
- Divide: restoring, one quotient bit per cycle. Quotient sign = sign(srca) xor sign(srcb). Remainder takes the sign of the dividend (truncating division).
- Divide by zero (srcb=0): lo = all ones, hi = srca unchanged. No exception is raised. Latency is the same as a normal divide.
- Signed overflow (most-negative / -1): lo = most-negative, hi = 0. This falls out of the magnitude algorithm with no special case.
- Timing:
  - busy=1 from the edge that accepts start through the FIX cycle.
  - done is registered, high in the cycle after the FIX edge, and busy=0 in that cycle.
  - With start sampled at edge 0, done is high in the cycle following edge WIDTH+1 (WIDTH+2 cycles of latency; 34 for WIDTH=32).
- start while busy=1 is ignored; no queuing.
- start and done in the same cycle: a new operation is accepted (back-to-back issue is allowed).
- hi_we/lo_we:
  - In IDLE, write wd into hi/lo at the next edge; both may be set together.
  - While busy=1, writes are ignored.
  - start together with hi_we/lo_we in IDLE: the write takes effect and the operation's FIX later overwrites it.
- hi/lo are stable except at the FIX edge or an accepted MTHI/MTLO write.
- Reset asserted mid-operation aborts: no done pulse is produced and hi/lo are cleared to 0.
- Arithmetic: all internal magnitudes are unsigned WIDTH+1 bits so |most-negative| is representable. No X on outputs for any op value.

Decomposition:
- Shared package mips_pkg:
  - muldiv_op_t enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU)
  - muldiv_state_t enum (MD_IDLE, MD_RUN, MD_FIX)
  - aluop/alucontrol localparams, reused by the controller for the new funct decodes
- Sub-module: cond_neg #(WIDTH), a conditional two's-complement negate. It is instantiated for operand magnitude on entry and for quotient, remainder and product correction in FIX. Everything else stays in mips_muldiv.

Test Plan:
- MULT with srca=0xFFFFFFFD (-3), srcb=7 -> done at cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB. busy is high on cycles 1-33 and low on cycle 34.
- MULTU with 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then DIVU 100/7 issued in the done cycle -> hi=2, lo=14, 34 cycles later.
- DIV -7/2 (0xFFFFFFF9, 2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x12345678/0 -> lo=0xFFFFFFFF, hi=0x12345678. Separately, start pulsed again mid-run -> ignored, single done pulse.
- MTHI wd=0xA5A5A5A5 and MTLO wd=0x5A5A5A5A in IDLE -> hi/lo updated next edge. Same writes while busy -> hi/lo unchanged until FIX.
- reset=0 at cycle 10 of a DIV -> busy=0, hi=lo=0 immediately, no done. WIDTH=8 build: MULT 0x80*0x80 -> hi=0x40, lo=0x00, done at cycle 10.
